// File: rtl/multiplier_sequencer.sv
// Sequencer and X/A/B registers for a signed shift-add multiplier.
// Ports: Clk, Reset_n, Run, ClearA_LoadB, Sw, Asum, Xsum -> Add, Sub, Aval, Bval, X, Done. Option: MULT_SKIP_ZERO_EN.
module multiplier_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] Sw,
  input  logic [WIDTH-1:0] Asum,
  input  logic             Xsum,
  output logic             Add,
  output logic             Sub,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] NITR = CW'(WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    a_d     = a_q;
    b_d     = b_q;
    Add     = 1'b0;
    Sub     = 1'b0;
    Done    = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (Run) begin
          state_d = S_START;
        end else if (ClearA_LoadB) begin
          x_d = 1'b0;
          a_d = '0;
          b_d = Sw;
        end
      end
      (state_q == S_START): begin
        x_d   = 1'b0;
        a_d   = '0;
        cnt_d = '0;
`ifdef MULT_SKIP_ZERO_EN
        state_d = b_q[0] ? S_ADD : S_SHIFT;
`else
        state_d = S_ADD;
`endif
      end
      (state_q == S_ADD): begin
        // Last multiplier bit carries negative weight.
        Add = b_q[0] & (cnt_q < LAST);
        Sub = b_q[0] & (cnt_q == LAST);
        if (Add | Sub) begin
          x_d = Xsum;
          a_d = Asum;
        end
        state_d = S_SHIFT;
      end
      (state_q == S_SHIFT): begin
        a_d   = {x_q, a_q[WIDTH-1:1]};
        b_d   = {a_q[0], b_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == NITR) begin
          state_d = S_DONE;
        end else begin
`ifdef MULT_SKIP_ZERO_EN
          // b_q[1] becomes the next M after this shift.
          state_d = b_q[1] ? S_ADD : S_SHIFT;
`else
          state_d = S_ADD;
`endif
        end
      end
      (state_q == S_DONE): begin
        Done = 1'b1;
        if (!Run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Self-checking bench for multiplier_sequencer.
// Models the nine-bit adder and scoreboards signed products.
module tb_multiplier_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] Sw;
  logic [7:0] Asum;
  logic       Xsum;
  logic       Add;
  logic       Sub;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       X;
  logic       Done;

  int total = 0;
  int bad = 0;
  logic [7:0] mB;
  logic [16:0] sb[$];
  logic [8:0] sum9;

  multiplier_sequencer #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run),
    .ClearA_LoadB(ClearA_LoadB), .Sw(Sw),
    .Asum(Asum), .Xsum(Xsum), .Add(Add), .Sub(Sub),
    .Aval(Aval), .Bval(Bval), .X(X), .Done(Done)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    if (Sub) sum9 = {Aval[7], Aval} - {Sw[7], Sw};
    else     sum9 = {Aval[7], Aval} + {Sw[7], Sw};
  end
  assign Asum = sum9[7:0];
  assign Xsum = sum9[8];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_b(input logic [7:0] v);
    Sw = v;
    ClearA_LoadB = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
    mB = v;
    chk("loadB", {X, Aval, Bval}, {9'd0, v});
  endtask

  task automatic mult(input logic [7:0] s, input logic clr);
    int a, b, n, subs, adds, both, subat, lat;
    logic [15:0] p;
    logic [16:0] e;
    a = $signed(mB);
    b = $signed(s);
    p = 16'(a * b);
    sb.push_back({p[15], p});
    lat = 17;
`ifdef MULT_SKIP_ZERO_EN
    lat = 9 + $countones(mB);
`endif
    Sw = s;
    Run = 1'b1;
    ClearA_LoadB = clr;
    tick();
    ClearA_LoadB = 1'b0;
    if (clr) chk("runWinsB", Bval, mB);
    n = 0; subs = 0; adds = 0; both = 0; subat = -1;
    while (!Done && n < 60) begin
      if (Add && Sub) both++;
      if (Sub) begin subs++; subat = n; end
      if (Add) adds++;
      tick();
      n++;
    end
    chk("latency", n, lat);
    e = sb.pop_front();
    chk("product", {X, Aval, Bval}, e);
    chk("exclusive", both, 0);
    chk("subCount", subs, {31'd0, mB[7]});
    chk("addCount", adds, $countones(mB[6:0]));
`ifndef MULT_SKIP_ZERO_EN
    if (mB[7]) chk("subAtLast", subat, 15);
`endif
    tick();
    tick();
    chk("holdDone", {Done, X, Aval, Bval}, {1'b1, e});
    Run = 1'b0;
    tick();
    chk("backIdle", {Done, Add, Sub}, 3'b000);
    mB = p[7:0];
  endtask

  initial begin
    Reset_n = 1'b0;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    Sw = 8'h00;
    tick();
    tick();
    chk("resetRegs", {X, Aval, Bval}, 17'd0);
    chk("resetOut", {Done, Add, Sub}, 3'b000);
    Reset_n = 1'b1;
    tick();

    load_b(8'h03);
    mult(8'h07, 1'b0);
    mult(8'h02, 1'b0);

    load_b(8'hFD);
    mult(8'h07, 1'b0);

    mult(8'h55, 1'b1);

    load_b(8'h80);
    mult(8'h80, 1'b0);

    load_b(8'h00);
    mult(8'h5A, 1'b0);

    load_b(8'hFF);
    mult(8'hFF, 1'b0);

    for (int i = 0; i < 4; i++) begin
      load_b(8'($urandom_range(0, 255)));
      mult(8'($urandom_range(0, 255)), 1'b0);
    end

    load_b(8'h6B);
    Sw = 8'h33;
    Run = 1'b1;
    tick();
    repeat (8) tick();
    Reset_n = 1'b0;
    Run = 1'b0;
    tick();
    Reset_n = 1'b1;
    chk("midReset", {Done, Add, Sub, X, Aval, Bval}, 20'd0);
    tick();
    chk("postReset", {Done, Add, Sub, X, Aval, Bval}, 20'd0);
    mB = 8'h00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
